button_event_gen: RTL and testbench

//   Front end for a push-button. Synchronises and debounces a raw board switch,

---
 rtl/button_event_gen.sv | 159 +++++++++++++++
 tb/tb_button_event_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// Push-button front end: synchronise and debounce a raw switch, then classify
// each press as press / short / long / auto-repeat single-cycle events.
module button_event_gen #(
    parameter int unsigned DEBOUNCE_LIMIT    = 250000,
    parameter int unsigned LONG_PRESS_CYCLES = 25000000,
    parameter int unsigned REPEAT_CYCLES     = 5000000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Short,
    output logic o_Long,
    output logic o_Repeat,
    output logic o_Held
);

    localparam int unsigned MAX_HOLD  = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                                        LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int unsigned MAX_LIMIT = (MAX_HOLD > DEBOUNCE_LIMIT) ?
                                        MAX_HOLD : DEBOUNCE_LIMIT;
    localparam int unsigned CNT_W     = $clog2(MAX_LIMIT) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    logic             sw_meta;
    logic             sw_s;
    logic             sw_d;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_nxt;
    state_t           state;
    state_t           state_nxt;
    logic             rise_c;
    logic             fall_c;
    logic             press_nxt;
    logic             short_nxt;
    logic             long_nxt;
    logic             repeat_nxt;
    logic             held_nxt;

    // Two-flop synchroniser for the asynchronous switch
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sw_meta <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sw_meta <= i_Switch;
            sw_s    <= sw_meta;
        end
    end

    // Debounce: level only follows after DEBOUNCE_LIMIT consecutive disagreeing samples
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Switch <= 1'b0;
            deb_cnt  <= '0;
            sw_d     <= 1'b0;
        end else begin
            sw_d <= o_Switch;
            if (sw_s != o_Switch) begin
                if (deb_cnt == DEB_LAST) begin
                    o_Switch <= sw_s;
                    deb_cnt  <= '0;
                end else begin
                    deb_cnt <= deb_cnt + CNT_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign rise_c = o_Switch & ~sw_d;
    assign fall_c = ~o_Switch & sw_d;

    // Event FSM state and registered pulse outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state    <= IDLE;
            hold_cnt <= '0;
            o_Press  <= 1'b0;
            o_Short  <= 1'b0;
            o_Long   <= 1'b0;
            o_Repeat <= 1'b0;
            o_Held   <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            o_Press  <= press_nxt;
            o_Short  <= short_nxt;
            o_Long   <= long_nxt;
            o_Repeat <= repeat_nxt;
            o_Held   <= held_nxt;
        end
    end

    // Next state; a release beats a threshold reached in the same cycle
    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold_cnt;
        press_nxt  = 1'b0;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        held_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (rise_c) begin
                    press_nxt = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (fall_c) begin
                    short_nxt = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = IDLE;
                end else if (hold_cnt == LONG_LAST) begin
                    long_nxt  = 1'b1;
                    held_nxt  = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = LONG_HELD;
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            LONG_HELD: begin
                if (fall_c) begin
                    hold_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    held_nxt = 1'b1;
                    if (hold_cnt == REP_LAST) begin
                        repeat_nxt = 1'b1;
                        hold_nxt   = '0;
                    end else begin
                        hold_nxt = hold_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                hold_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_button_event_gen.sv
// Self-checking bench for button_event_gen: directed scenarios plus random
// switch traffic compared cycle by cycle against a window/episode model.
module tb_button_event_gen;

    localparam int DEB   = 4;
    localparam int LONGC = 20;
    localparam int REP   = 8;
    localparam int MAXT  = 4096;

    logic i_Clk = 1'b0;
    logic i_Rst_L;
    logic i_Switch;
    logic o_Switch, o_Press, o_Short, o_Long, o_Repeat, o_Held;

    button_event_gen #(
        .DEBOUNCE_LIMIT   (DEB),
        .LONG_PRESS_CYCLES(LONGC),
        .REPEAT_CYCLES    (REP)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch),
        .o_Press (o_Press),
        .o_Short (o_Short),
        .o_Long  (o_Long),
        .o_Repeat(o_Repeat),
        .o_Held  (o_Held)
    );

    always #5 i_Clk = ~i_Clk;

    int errors = 0;
    int checks = 0;

    // Model history: switch value captured at each edge since reset, debounced level after it
    bit in_s [MAXT];
    bit deb  [MAXT];
    int t;
    bit ep_active;
    int ep_start;

    int t_start, n_press, n_short, n_long, n_repeat, n_sw_high;
    int first_sw_t, first_press_t, first_long_t, first_repeat_t;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit in_at(input int k);
        return (k >= 1) ? in_s[k] : 1'b0;
    endfunction

    function automatic bit deb_at(input int k);
        return (k >= 0) ? deb[k] : 1'b0;
    endfunction

    task automatic reset_model();
        t         = 0;
        deb[0]    = 1'b0;
        ep_active = 1'b0;
        ep_start  = 0;
    endtask

    task automatic clear_tally();
        t_start        = t;
        n_press        = 0;
        n_short        = 0;
        n_long         = 0;
        n_repeat       = 0;
        n_sw_high      = 0;
        first_sw_t     = -1;
        first_press_t  = -1;
        first_long_t   = -1;
        first_repeat_t = -1;
    endtask

    // One clock: advance the model, then compare every output just after the edge
    task automatic tick();
        bit flip, rise, fall;
        bit e_press, e_short, e_long, e_repeat, e_held;
        int d;
        @(posedge i_Clk);
        t++;
        if (t >= MAXT) begin
            $display("FAIL model_depth t=%0d limit=%0d", t, MAXT);
            $fatal(1, "model history exhausted");
        end
        in_s[t] = i_Switch;
        // Synced sample seen at edge t is the value captured two edges earlier
        flip = 1'b1;
        for (int j = 0; j < DEB; j++)
            if (in_at(t - 2 - j) == deb[t-1]) flip = 1'b0;
        deb[t] = flip ? ~deb[t-1] : deb[t-1];

        rise = deb_at(t-1) & ~deb_at(t-2);
        fall = ~deb_at(t-1) & deb_at(t-2);
        e_press = 1'b0; e_short = 1'b0; e_long = 1'b0; e_repeat = 1'b0; e_held = 1'b0;
        if (rise) begin
            e_press   = 1'b1;
            ep_active = 1'b1;
            ep_start  = t;
        end else if (ep_active) begin
            d = t - ep_start;
            if (fall) begin
                e_short   = (d <= LONGC);
                ep_active = 1'b0;
            end else begin
                e_held   = (d >= LONGC);
                e_long   = (d == LONGC);
                e_repeat = (d > LONGC) && (((d - LONGC) % REP) == 0);
            end
        end
        #1;
        chk("o_Switch", o_Switch, deb[t]);
        chk("o_Press",  o_Press,  e_press);
        chk("o_Short",  o_Short,  e_short);
        chk("o_Long",   o_Long,   e_long);
        chk("o_Repeat", o_Repeat, e_repeat);
        chk("o_Held",   o_Held,   e_held);
        if (o_Switch === 1'b1) begin
            n_sw_high++;
            if (first_sw_t < 0) first_sw_t = t;
        end
        if (o_Press === 1'b1) begin
            n_press++;
            if (first_press_t < 0) first_press_t = t;
        end
        if (o_Short === 1'b1) n_short++;
        if (o_Long === 1'b1) begin
            n_long++;
            if (first_long_t < 0) first_long_t = t;
        end
        if (o_Repeat === 1'b1) begin
            n_repeat++;
            if (first_repeat_t < 0) first_repeat_t = t;
        end
    endtask

    task automatic run(input bit v, input int n);
        i_Switch = v;
        repeat (n) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sw"},     o_Switch, 1'b0);
        chk({tag, "_press"},  o_Press,  1'b0);
        chk({tag, "_short"},  o_Short,  1'b0);
        chk({tag, "_long"},   o_Long,   1'b0);
        chk({tag, "_repeat"}, o_Repeat, 1'b0);
        chk({tag, "_held"},   o_Held,   1'b0);
    endtask

    initial begin
        i_Rst_L  = 1'b0;
        i_Switch = 1'b0;
        reset_model();
        clear_tally();
        repeat (3) @(posedge i_Clk);
        #1;
        chk_all_zero("reset");
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        run(1'b0, 5);

        // Glitch shorter than the debounce window
        clear_tally();
        run(1'b1, 3);
        run(1'b0, 12);
        chk_int("glitch_sw_high", n_sw_high, 0);
        chk_int("glitch_press", n_press, 0);

        // Short press
        clear_tally();
        run(1'b1, 15);
        run(1'b0, 15);
        chk_int("short_sw_latency", first_sw_t - t_start, 6);
        chk_int("short_press", n_press, 1);
        chk_int("short_short", n_short, 1);
        chk_int("short_long", n_long, 0);
        chk_int("short_repeat", n_repeat, 0);

        // Long hold: fifth repeat coincides with release and is suppressed
        clear_tally();
        run(1'b1, 60);
        run(1'b0, 15);
        chk_int("long_press", n_press, 1);
        chk_int("long_long", n_long, 1);
        chk_int("long_delay", first_long_t - first_press_t, LONGC);
        chk_int("long_rep_delay", first_repeat_t - first_long_t, REP);
        chk_int("long_repeat", n_repeat, 4);
        chk_int("long_short", n_short, 0);

        // Release lands on the long threshold
        clear_tally();
        run(1'b1, 20);
        run(1'b0, 15);
        chk_int("coll_short", n_short, 1);
        chk_int("coll_long", n_long, 0);

        // Asynchronous reset while long-held
        clear_tally();
        run(1'b1, 30);
        chk("pre_reset_held", o_Held, 1'b1);
        @(negedge i_Clk);
        #2;
        i_Rst_L = 1'b0;
        #1;
        chk_all_zero("async_reset");
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        reset_model();
        clear_tally();
        run(1'b1, 12);
        chk_int("post_reset_press_at", first_press_t - t_start, 7);
        chk_int("post_reset_press_n", n_press, 1);
        run(1'b0, 15);

        // Bounce train then a steady press
        clear_tally();
        for (int i = 0; i < 10; i++) run(((i % 2) == 0) ? 1'b1 : 1'b0, 2);
        run(1'b1, 15);
        chk_int("bounce_press", n_press, 1);
        chk_int("bounce_short", n_short, 0);
        run(1'b0, 25);

        // Random switch traffic against the model
        repeat (60) run(1'($urandom_range(0, 1)), int'($urandom_range(1, 45)));
        run(1'b0, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
